// File: rtl/custom_buff_use_sequencer_pkg.sv
// Shared types and constants for the Custom buffer-use sequencer: FSM states,
// the default schedule and a parameter sanity check.
package custom_buff_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int unsigned DEFAULT_LEN = 26;
  localparam int unsigned DEFAULT_W   = 4;

  // Step 0 in the least significant nibble.
  localparam logic [DEFAULT_LEN*DEFAULT_W-1:0] DEFAULT_SCHED = {
    4'h8, 4'h9, 4'h3, 4'h2, 4'hC, 4'h8, 4'hD, 4'h1, 4'hB, 4'h3, 4'h2, 4'h6, 4'h4,
    4'hE, 4'h8, 4'hD, 4'h9, 4'h2, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0
  };

  function automatic logic [DEFAULT_W-1:0] default_entry(input int unsigned idx);
    return (idx < DEFAULT_LEN) ? DEFAULT_SCHED[idx*DEFAULT_W +: DEFAULT_W] : '0;
  endfunction

  function automatic bit params_ok(input int unsigned num_buff, input int unsigned cnt_w,
                                   input int unsigned depth);
    return (num_buff >= 1) && (cnt_w >= 1) && (cnt_w < 31) &&
           (depth >= 1) && (depth <= (32'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/custom_buff_use_sequencer_if.sv
// Control/status bundle between the Custom controller (master) and the sequencer (slave).
interface custom_buff_use_sequencer_if #(
  parameter int unsigned NUM_BUFF = 4,
  parameter int unsigned CNT_W    = 5
) ();
  logic                start;
  logic                abort;
  logic                stall;
  logic                loop_en;
  logic [CNT_W-1:0]    seq_last;
  logic                tbl_we;
  logic [CNT_W-1:0]    tbl_addr;
  logic [NUM_BUFF-1:0] tbl_wdata;
  logic                tbl_werr;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_BUFF-1:0] buff_use;
  logic                buff_valid;

  modport master (
    output start, abort, stall, loop_en, seq_last, tbl_we, tbl_addr, tbl_wdata,
    input  tbl_werr, busy, done, cnt, buff_use, buff_valid
  );

  modport slave (
    input  start, abort, stall, loop_en, seq_last, tbl_we, tbl_addr, tbl_wdata,
    output tbl_werr, busy, done, cnt, buff_use, buff_valid
  );
endinterface

// File: rtl/custom_buff_use_sequencer_sched_table.sv
// Schedule register file: sync write, async read, reset reloads the default schedule.
module custom_buff_sched_table
  import custom_buff_pkg::*;
#(
  parameter int unsigned NUM_BUFF = 4,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned DEPTH    = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [CNT_W-1:0]    waddr,
  input  logic [NUM_BUFF-1:0] wdata,
  input  logic [CNT_W-1:0]    raddr,
  output logic [NUM_BUFF-1:0] rdata
);

  logic [NUM_BUFF-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (NUM_BUFF == DEFAULT_W) ? NUM_BUFF'(default_entry(i)) : '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/custom_buff_use_sequencer.sv
// Buffer-use sequencer: step counter and IDLE/RUN control that plays the schedule
// table out as one registered use-enable mask per step.
module custom_buff_use_sequencer
  import custom_buff_pkg::*;
#(
  parameter int unsigned NUM_BUFF = 4,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned DEPTH    = 26
) (
  input  logic                         clk,
  input  logic                         rst_n,
  custom_buff_use_sequencer_if.slave   bus
);

  if (!params_ok(NUM_BUFF, CNT_W, DEPTH)) begin : g_bad_params
    $error("custom_buff_use_sequencer: illegal NUM_BUFF/CNT_W/DEPTH");
  end

  localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(DEPTH - 1);

  state_e              state;
  logic [CNT_W-1:0]    seq_last_q;
  logic [CNT_W-1:0]    nxt_idx_c;
  logic [CNT_W-1:0]    clamp_c;
  logic [NUM_BUFF-1:0] rd_data;
  logic [NUM_BUFF-1:0] load_c;
  logic                wr_ok_c;
  logic                last_c;

  // Next table index and its mask; a same-cycle write to that index is forwarded.
  always_comb begin
    wr_ok_c   = bus.tbl_we && (state == IDLE) && (32'(bus.tbl_addr) < DEPTH);
    last_c    = (bus.cnt == seq_last_q);
    nxt_idx_c = '0;
    if ((state == RUN) && !last_c) nxt_idx_c = bus.cnt + CNT_W'(1);
    load_c    = (wr_ok_c && (bus.tbl_addr == nxt_idx_c)) ? bus.tbl_wdata : rd_data;
    clamp_c   = (bus.seq_last > LAST_MAX) ? LAST_MAX : bus.seq_last;
  end

  custom_buff_sched_table #(
    .NUM_BUFF (NUM_BUFF),
    .CNT_W    (CNT_W),
    .DEPTH    (DEPTH)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok_c),
    .waddr (bus.tbl_addr),
    .wdata (bus.tbl_wdata),
    .raddr (nxt_idx_c),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      seq_last_q     <= LAST_MAX;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.tbl_werr   <= 1'b0;
      bus.cnt        <= '0;
      bus.buff_use   <= '0;
      bus.buff_valid <= 1'b0;
    end else begin
      bus.tbl_werr <= bus.tbl_we && !wr_ok_c;
      bus.done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state          <= RUN;
            seq_last_q     <= clamp_c;
            bus.busy       <= 1'b1;
            bus.cnt        <= '0;
            bus.buff_use   <= load_c;
            bus.buff_valid <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort || (!bus.stall && last_c && !bus.loop_en)) begin
            // End of pass without looping also lands here, but only it reports done.
            state          <= IDLE;
            bus.done       <= !bus.abort;
            bus.busy       <= 1'b0;
            bus.cnt        <= '0;
            bus.buff_use   <= '0;
            bus.buff_valid <= 1'b0;
          end else if (!bus.stall) begin
            bus.done     <= last_c;
            bus.cnt      <= nxt_idx_c;
            bus.buff_use <= load_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_custom_buff_use_sequencer.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks.
module tb_custom_buff_use_sequencer;

  localparam int NB = 4;
  localparam int CW = 5;
  localparam int DP = 26;
  localparam logic [3:0] DEF [26] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'hC, 4'h6, 4'h2,
                                      4'h9, 4'hD, 4'h8, 4'hE, 4'h4, 4'h6, 4'h2, 4'h3, 4'hB,
                                      4'h1, 4'hD, 4'h8, 4'hC, 4'h2, 4'h3, 4'h9, 4'h8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  custom_buff_use_sequencer_if #(.NUM_BUFF(NB), .CNT_W(CW)) bus ();

  custom_buff_use_sequencer #(.NUM_BUFF(NB), .CNT_W(CW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: sequence semantics expressed with plain integers.
  int  m_tbl [DP];
  bit  m_run;
  int  m_step, m_last, m_use;
  bit  m_done, m_werr;

  always @(posedge clk) begin
    bit wr_ok;
    if (!rst_n) begin
      for (int i = 0; i < DP; i++) m_tbl[i] = int'(DEF[i]);
      m_run = 0; m_step = 0; m_last = DP - 1; m_use = 0; m_done = 0; m_werr = 0;
    end else begin
      wr_ok  = bus.tbl_we && !m_run && (int'(bus.tbl_addr) < DP);
      m_werr = bus.tbl_we && !wr_ok;
      m_done = 0;
      if (!m_run) begin
        if (wr_ok) m_tbl[int'(bus.tbl_addr)] = int'(bus.tbl_wdata);
        if (bus.start && !bus.abort) begin
          m_run  = 1;
          m_last = (int'(bus.seq_last) > DP - 1) ? DP - 1 : int'(bus.seq_last);
          m_step = 0;
          m_use  = m_tbl[0];
        end
      end else if (bus.abort) begin
        m_run = 0; m_step = 0; m_use = 0;
      end else if (!bus.stall) begin
        if (m_step == m_last) begin
          m_done = 1;
          m_step = 0;
          if (bus.loop_en) m_use = m_tbl[0];
          else begin m_run = 0; m_use = 0; end
        end else begin
          m_step++;
          m_use = m_tbl[m_step];
        end
      end
    end
    #1;
    chk("busy", int'(bus.busy), int'(m_run));
    chk("buff_valid", int'(bus.buff_valid), int'(m_run));
    chk("done", int'(bus.done), int'(m_done));
    chk("tbl_werr", int'(bus.tbl_werr), int'(m_werr));
    chk("cnt", int'(bus.cnt), m_step);
    chk("buff_use", int'(bus.buff_use), m_use);
  end

  int q_use[$];
  int q_done[$];

  function automatic int qget(input int i);
    return (i < q_use.size()) ? q_use[i] : -1;
  endfunction

  function automatic int dget(input int i);
    return (i < q_done.size()) ? q_done[i] : -1;
  endfunction

  task automatic clear_inputs();
    bus.start = 0; bus.abort = 0; bus.stall = 0; bus.loop_en = 0;
    bus.seq_last = '0; bus.tbl_we = 0; bus.tbl_addr = '0; bus.tbl_wdata = '0;
  endtask

  // Start a run and record buff_use/done at each negedge while busy.
  task automatic run_collect(input string tag, input int sl, input bit lp, input int limit,
                             input int st_at, input int st_len);
    int n;
    int left;
    q_use.delete();
    q_done.delete();
    @(negedge clk);
    bus.start = 1; bus.seq_last = CW'(sl); bus.loop_en = lp;
    @(negedge clk);
    bus.start = 0;
    n = 0;
    left = st_len;
    while (bus.busy && n < limit) begin
      q_use.push_back(int'(bus.buff_use));
      q_done.push_back(int'(bus.done));
      bus.stall = (int'(bus.cnt) == st_at) && (left > 0);
      if (bus.stall) left--;
      @(negedge clk);
      n++;
    end
    bus.stall = 0;
    if (!lp) begin
      chk({tag, "_end_busy"}, int'(bus.busy), 0);
      chk({tag, "_end_done"}, int'(bus.done), 1);
      chk({tag, "_end_use"}, int'(bus.buff_use), 0);
    end
  endtask

  task automatic write_tbl(input int addr, input int data);
    @(negedge clk);
    bus.tbl_we = 1; bus.tbl_addr = CW'(addr); bus.tbl_wdata = NB'(data);
    @(negedge clk);
    bus.tbl_we = 0;
  endtask

  initial begin
    int n;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_valid", int'(bus.buff_valid), 0);
    chk("rst_use", int'(bus.buff_use), 0);

    // Full default pass.
    run_collect("t1", 25, 0, 60, -1, 0);
    chk("t1_len", q_use.size(), 26);
    chk("t1_s0", qget(0), 0);
    chk("t1_s5", qget(5), 8);
    chk("t1_s6", qget(6), 12);
    chk("t1_s9", qget(9), 9);
    chk("t1_s25", qget(25), 8);

    // Stall three cycles at step 6.
    run_collect("t2", 25, 0, 60, 6, 3);
    chk("t2_len", q_use.size(), 29);
    chk("t2_s6", qget(6), 12);
    chk("t2_s9", qget(9), 12);
    chk("t2_s10", qget(10), 6);
    chk("t2_s28", qget(28), 8);

    // Abort mid-run.
    @(negedge clk);
    bus.start = 1; bus.seq_last = 5'd25;
    @(negedge clk);
    bus.start = 0;
    n = 0;
    while (int'(bus.cnt) != 10 && n < 50) begin @(negedge clk); n++; end
    chk("t4_reach", int'(bus.cnt), 10);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_valid", int'(bus.buff_valid), 0);
    chk("t4_done", int'(bus.done), 0);
    chk("t4_use", int'(bus.buff_use), 0);

    // Rejected writes: out of range in IDLE, any address while running.
    write_tbl(30, 5);
    chk("t5_werr_range", int'(bus.tbl_werr), 1);
    write_tbl(5, 15);
    chk("t5_werr_ok", int'(bus.tbl_werr), 0);
    @(negedge clk);
    bus.start = 1; bus.seq_last = 5'd25;
    @(negedge clk);
    bus.start = 0; bus.tbl_we = 1; bus.tbl_addr = 5'd3; bus.tbl_wdata = 4'h7;
    @(negedge clk);
    bus.tbl_we = 0;
    chk("t5_werr_run", int'(bus.tbl_werr), 1);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;

    // Clamped seq_last; table[3] untouched, table[5] rewritten.
    run_collect("t6", 31, 0, 60, -1, 0);
    chk("t6_len", q_use.size(), 26);
    chk("t6_s3", qget(3), 0);
    chk("t6_s5", qget(5), 15);

    // start+abort in IDLE stays idle.
    @(negedge clk);
    bus.start = 1; bus.abort = 1;
    @(negedge clk);
    bus.start = 0; bus.abort = 0;
    chk("t6_sa_busy", int'(bus.busy), 0);

    // Loop mode over a 3-step schedule.
    write_tbl(0, 1);
    write_tbl(1, 2);
    write_tbl(2, 4);
    run_collect("t3", 2, 1, 7, -1, 0);
    chk("t3_s3", qget(3), 1);
    chk("t3_s5", qget(5), 4);
    chk("t3_s6", qget(6), 1);
    chk("t3_d1", dget(1), 0);
    chk("t3_d3", dget(3), 1);
    chk("t3_d6", dget(6), 1);
    bus.abort = 1; bus.loop_en = 0;
    @(negedge clk);
    bus.abort = 0;
    chk("t3_abort_busy", int'(bus.busy), 0);

    // Write-through to step 0 with a single-step sequence.
    @(negedge clk);
    bus.start = 1; bus.seq_last = '0; bus.tbl_we = 1; bus.tbl_addr = '0; bus.tbl_wdata = 4'h9;
    @(negedge clk);
    clear_inputs();
    chk("wt_use", int'(bus.buff_use), 9);
    @(negedge clk);
    chk("wt_done", int'(bus.done), 1);
    chk("wt_busy", int'(bus.busy), 0);

    // Randomised traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.abort     = ($urandom_range(0, 49) == 0);
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.loop_en   = ($urandom_range(0, 3) == 0);
      bus.seq_last  = CW'($urandom_range(0, 31));
      bus.tbl_we    = ($urandom_range(0, 19) == 0);
      bus.tbl_addr  = CW'($urandom_range(0, 31));
      bus.tbl_wdata = NB'($urandom);
      if (c % 500 == 499) rst_n = 0;
      else rst_n = 1;
    end
    @(negedge clk);
    clear_inputs();
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
